// File: rtl/dmem_arb_pkg.sv
// Shared types and bounds for the data-memory arbiter: owner encoding,
// the {valid, owner} read tag, and the legal RD_LAT / MAX_WAIT ranges.
package dmem_arb_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 4;
  localparam int MAX_WAIT_MIN = 1;
  localparam int MAX_WAIT_MAX = 255;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/dmem_arb_tag_pipe.sv
// RD_LAT-deep shift register of read tags; its output stage lines up with
// the cycle in which the SRAM presents read data.
module dmem_arb_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  tag_t              tag_in;
  tag_t [RD_LAT:1]   tag_pipe;

  assign tag_in = '{valid: in_valid, owner: in_owner};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= tag_in;
      for (int i = 2; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_valid = tag_pipe[RD_LAT].valid;
  assign out_owner = tag_pipe[RD_LAT].owner;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage / host loader) arbiter for the data SRAM port.
// Default: CPU priority with MAX_WAIT host starvation guard; define
// DMEM_ARB_RR_EN for round-robin arbitration instead.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT=%0d out of range", RD_LAT);
  end
  if (MAX_WAIT < MAX_WAIT_MIN || MAX_WAIT > MAX_WAIT_MAX) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT=%0d out of range", MAX_WAIT);
  end

`ifdef DMEM_ARB_RR_EN
  // Tie goes to whoever was not served last; resets to host so CPU wins first.
  logic last_owner;

  assign cpu_gnt = cpu_req & (~ext_req | (last_owner == OWNER_EXT));
  assign ext_gnt = ext_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)         last_owner <= OWNER_EXT;
    else if (cpu_gnt) last_owner <= OWNER_CPU;
    else if (ext_gnt) last_owner <= OWNER_EXT;
  end
`else
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       ext_force;

  assign ext_force = ext_req & (wait_cnt == WAIT_LIMIT);
  assign cpu_gnt   = cpu_req & ~ext_force;
  assign ext_gnt   = ext_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                       wait_cnt <= '0;
    else if (~ext_req | ext_gnt)    wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 8'd1;
  end
`endif

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  logic tag_valid;
  logic tag_owner;

  dmem_arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (mem_ren),
    .in_owner  (ext_gnt),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  assign cpu_rvalid = tag_valid & (tag_owner == OWNER_CPU);
  assign ext_rvalid = tag_valid & (tag_owner == OWNER_EXT);

  // Each side sees live SRAM data on its own return, else its last return.
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ext_rvalid) ext_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = ext_rvalid ? mem_rdata : ext_rdata_q;

endmodule
